// File: rtl/frag_data_buffer_pkg.sv
// Shared constants and types for the TX-path fragmentation buffer (package data_frag_package).
// Build option: FRAG_BUF_ERR_EN adds sticky overflow/underflow flags on the top level.
package data_frag_package;

    localparam int unsigned DW              = 32;
    localparam int unsigned LOC_WIDTH       = 4 * DW;
    localparam int unsigned DEPTH           = 256;
    localparam int unsigned MAX_WR_LOC      = 8;
    localparam int unsigned WR_DATA_WIDTH   = MAX_WR_LOC * LOC_WIDTH;
    localparam int unsigned NO_LOC_WR_WIDTH = 4;
    localparam int unsigned COUNT_WIDTH     = 9;
    localparam int unsigned PTR_WIDTH       = $clog2(DEPTH);

    typedef logic [LOC_WIDTH-1:0]   loc_t;
    typedef logic [PTR_WIDTH-1:0]   ptr_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    // Circular index advance; wraps modulo DEPTH through the pointer width.
    function automatic ptr_t ptr_add(ptr_t base, ptr_t offset);
        return ptr_t'(base + offset);
    endfunction

endpackage

// File: rtl/frag_data_buffer_mem.sv
// DEPTH x LOC_WIDTH storage with MAX_WR_LOC write lanes and two adjacent combinational read ports.
// Build option: FRAG_BUF_ERR_EN does not affect this module.
module frag_buf_mem
    import data_frag_package::*;
(
    input  logic                           clk,
    input  logic [MAX_WR_LOC-1:0]          lane_en,
    input  ptr_t [MAX_WR_LOC-1:0]          lane_idx,
    input  logic [WR_DATA_WIDTH-1:0]       lane_data,
    input  ptr_t                           rd_idx,
    output loc_t                           rd_data_a_c,
    output loc_t                           rd_data_b_c
);

    loc_t mem [DEPTH];
    ptr_t rd_idx_next;

    // Lane indices are always distinct (at most 8 consecutive slots of 256).
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(MAX_WR_LOC); i++) begin
            if (lane_en[i]) begin
                mem[lane_idx[i]] <= lane_data[i*LOC_WIDTH +: LOC_WIDTH];
            end
        end
    end

    always_comb begin
        rd_idx_next = ptr_add(rd_idx, ptr_t'(1));
        rd_data_a_c = mem[rd_idx];
        rd_data_b_c = mem[rd_idx_next];
    end

endmodule

// File: rtl/frag_data_buffer.sv
// Circular buffer between the TX arbiter (1..8 locations/cycle in) and fragmentation (1-2 out, registered).
// Build option: define FRAG_BUF_ERR_EN to expose sticky ovf_err/udf_err flags.
module frag_data_buffer
    import data_frag_package::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WR_DATA_WIDTH-1:0]    data_in,
    input  logic [NO_LOC_WR_WIDTH-1:0]  no_loc_wr,
    output logic [COUNT_WIDTH-1:0]      empty_loc,
    input  logic                        rd_en,
    input  logic                        rd_mode,
    output logic [LOC_WIDTH-1:0]        rd_data_1,
    output logic [LOC_WIDTH-1:0]        rd_data_2,
    output logic [COUNT_WIDTH-1:0]      Count
`ifdef FRAG_BUF_ERR_EN
    ,
    output logic                        ovf_err,
    output logic                        udf_err
`endif
);

    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    count_t                wr_n;
    count_t                rd_n;
    count_t                wr_add;
    count_t                rd_sub;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_too_big;
    logic [MAX_WR_LOC-1:0] lane_en;
    ptr_t [MAX_WR_LOC-1:0] lane_idx;
    loc_t                  mem_rd_a_c;
    loc_t                  mem_rd_b_c;

    assign empty_loc = count_t'(DEPTH) - Count;

    // Acceptance uses current-cycle occupancy only; a same-cycle pop never frees space.
    always_comb begin
        wr_n       = count_t'(no_loc_wr);
        rd_n       = rd_mode ? count_t'(2) : count_t'(1);
        wr_too_big = wr_n > empty_loc;
        wr_ok      = wr_en && (wr_n != '0) && (wr_n <= count_t'(MAX_WR_LOC)) && !wr_too_big;
        rd_ok      = rd_en && (Count >= rd_n);
        wr_add     = wr_ok ? wr_n : '0;
        rd_sub     = rd_ok ? rd_n : '0;
        for (int i = 0; i < int'(MAX_WR_LOC); i++) begin
            lane_en[i]  = wr_ok && (NO_LOC_WR_WIDTH'(i) < no_loc_wr);
            lane_idx[i] = ptr_add(wr_ptr, PTR_WIDTH'(i));
        end
    end

    frag_buf_mem u_mem (
        .clk         (clk),
        .lane_en     (lane_en),
        .lane_idx    (lane_idx),
        .lane_data   (data_in),
        .rd_idx      (rd_ptr),
        .rd_data_a_c (mem_rd_a_c),
        .rd_data_b_c (mem_rd_b_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Count     <= '0;
            rd_data_1 <= '0;
            rd_data_2 <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_add(wr_ptr, PTR_WIDTH'(no_loc_wr));
            end
            if (rd_ok) begin
                rd_ptr    <= ptr_add(rd_ptr, PTR_WIDTH'(rd_n));
                rd_data_1 <= mem_rd_a_c;
                rd_data_2 <= rd_mode ? mem_rd_b_c : '0;
            end
            Count <= Count + wr_add - rd_sub;
        end
    end

`ifdef FRAG_BUF_ERR_EN
    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_en && wr_too_big) begin
                ovf_err <= 1'b1;
            end
            if (rd_en && !rd_ok) begin
                udf_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frag_data_buffer.sv
// Self-checking bench for frag_data_buffer: queue-based reference model plus directed literal checks.
// Build option: FRAG_BUF_ERR_EN enables checks of the sticky error flags.
module tb_frag_data_buffer;
    import data_frag_package::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        wr_en;
    logic [WR_DATA_WIDTH-1:0]    data_in;
    logic [NO_LOC_WR_WIDTH-1:0]  no_loc_wr;
    logic [COUNT_WIDTH-1:0]      empty_loc;
    logic                        rd_en;
    logic                        rd_mode;
    logic [LOC_WIDTH-1:0]        rd_data_1;
    logic [LOC_WIDTH-1:0]        rd_data_2;
    logic [COUNT_WIDTH-1:0]      Count;
`ifdef FRAG_BUF_ERR_EN
    logic                        ovf_err;
    logic                        udf_err;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    frag_data_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .no_loc_wr (no_loc_wr),
        .empty_loc (empty_loc),
        .rd_en     (rd_en),
        .rd_mode   (rd_mode),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2),
        .Count     (Count)
`ifdef FRAG_BUF_ERR_EN
        ,
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
`endif
    );

    function automatic loc_t mk(logic [31:0] v);
        return {v, ~v, v ^ 32'h5a5a_5a5a, v + 32'd1};
    endfunction

    task automatic check(string name, loc_t act, loc_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a FIFO of locations with the acceptance rules applied to pre-cycle occupancy.
    loc_t q[$];
    loc_t m_d1, m_d2;
    bit   m_ovf, m_udf, m_valid;

    always @(posedge clk) begin
        int  n;
        int  need;
        int  free;
        bit  wok;
        bit  rok;
        if (rst) begin
            q.delete();
            m_d1    = '0;
            m_d2    = '0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            n    = int'(no_loc_wr);
            need = rd_mode ? 2 : 1;
            free = int'(DEPTH) - q.size();
            wok  = wr_en && n >= 1 && n <= int'(MAX_WR_LOC) && n <= free;
            rok  = rd_en && q.size() >= need;
            if (wr_en && n > free) m_ovf = 1'b1;
            if (rd_en && !rok)     m_udf = 1'b1;
            if (rok) begin
                m_d1 = q.pop_front();
                m_d2 = rd_mode ? q.pop_front() : '0;
            end
            if (wok) begin
                for (int i = 0; i < n; i++) q.push_back(data_in[i*LOC_WIDTH +: LOC_WIDTH]);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", LOC_WIDTH'(Count), LOC_WIDTH'(q.size()));
            check("model_empty_loc", LOC_WIDTH'(empty_loc), LOC_WIDTH'(int'(DEPTH) - q.size()));
            check("model_rd_data_1", rd_data_1, m_d1);
            check("model_rd_data_2", rd_data_2, m_d2);
`ifdef FRAG_BUF_ERR_EN
            check("model_ovf_err", LOC_WIDTH'(ovf_err), LOC_WIDTH'(m_ovf));
            check("model_udf_err", LOC_WIDTH'(udf_err), LOC_WIDTH'(m_udf));
`endif
        end
    end

    task automatic drive(bit we, int n, logic [31:0] base, bit re, bit mode);
        wr_en     = we;
        no_loc_wr = NO_LOC_WR_WIDTH'(n);
        for (int i = 0; i < int'(MAX_WR_LOC); i++) begin
            data_in[i*LOC_WIDTH +: LOC_WIDTH] = mk(base + 32'(i));
        end
        rd_en   = re;
        rd_mode = mode;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_mode = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_mode   = 1'b0;
        no_loc_wr = '0;
        data_in   = '0;
        drive(0, 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        rst = 1'b0;
        check("reset_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));
        check("reset_empty_loc", LOC_WIDTH'(empty_loc), LOC_WIDTH'(256));

        // Write A,B,C then pop two.
        drive(1, 3, 32'h100, 0, 0);
        check("t1_count", LOC_WIDTH'(Count), LOC_WIDTH'(3));
        check("t1_empty_loc", LOC_WIDTH'(empty_loc), LOC_WIDTH'(253));
        drive(0, 0, 32'h0, 1, 1);
        check("t1_rd1", rd_data_1, mk(32'h100));
        check("t1_rd2", rd_data_2, mk(32'h101));
        check("t1_count_after", LOC_WIDTH'(Count), LOC_WIDTH'(1));

        // Pop-two with one stored is rejected; then pop one.
        drive(0, 0, 32'h0, 1, 1);
        check("t2_count_hold", LOC_WIDTH'(Count), LOC_WIDTH'(1));
        check("t2_rd1_hold", rd_data_1, mk(32'h100));
        check("t2_rd2_hold", rd_data_2, mk(32'h101));
`ifdef FRAG_BUF_ERR_EN
        check("t2_udf", LOC_WIDTH'(udf_err), LOC_WIDTH'(1));
`endif
        drive(0, 0, 32'h0, 1, 0);
        check("t2_rd1", rd_data_1, mk(32'h102));
        check("t2_rd2_zero", rd_data_2, LOC_WIDTH'(0));
        check("t2_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));

        // Fill to 252, oversize write rejected, then fill to full.
        do_reset();
        for (int k = 0; k < 31; k++) drive(1, 8, 32'h1000 + 32'(k * 8), 0, 0);
        drive(1, 4, 32'h2000, 0, 0);
        check("t3_count_252", LOC_WIDTH'(Count), LOC_WIDTH'(252));
        drive(1, 5, 32'h2100, 0, 0);
        check("t3_count_rej", LOC_WIDTH'(Count), LOC_WIDTH'(252));
`ifdef FRAG_BUF_ERR_EN
        check("t3_ovf", LOC_WIDTH'(ovf_err), LOC_WIDTH'(1));
`endif
        drive(1, 4, 32'h2200, 0, 0);
        check("t3_count_full", LOC_WIDTH'(Count), LOC_WIDTH'(256));
        check("t3_empty_zero", LOC_WIDTH'(empty_loc), LOC_WIDTH'(0));
        drive(1, 1, 32'h2300, 0, 0);
        check("t3_full_rej", LOC_WIDTH'(Count), LOC_WIDTH'(256));
        drive(0, 0, 32'h0, 1, 0);
        check("t3_first_out", rd_data_1, mk(32'h1000));

        // Illegal lengths and empty reads.
        do_reset();
        drive(1, 0, 32'h3000, 0, 0);
        check("len0_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));
        drive(1, 9, 32'h3100, 0, 0);
        check("len9_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));
`ifdef FRAG_BUF_ERR_EN
        check("len9_no_ovf", LOC_WIDTH'(ovf_err), LOC_WIDTH'(0));
`endif
        drive(0, 0, 32'h0, 1, 0);
        check("empty_rd_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));

        // Walk both pointers to 254, then write across the wrap.
        do_reset();
        for (int k = 0; k < 31; k++) drive(1, 8, 32'h4000 + 32'(k * 8), 0, 0);
        drive(1, 6, 32'h4800, 0, 0);
        check("t4_count_254", LOC_WIDTH'(Count), LOC_WIDTH'(254));
        for (int k = 0; k < 127; k++) drive(0, 0, 32'h0, 1, 1);
        check("t4_drained", LOC_WIDTH'(Count), LOC_WIDTH'(0));
        drive(1, 4, 32'h5000, 0, 0);
        drive(0, 0, 32'h0, 1, 1);
        check("t4_w0", rd_data_1, mk(32'h5000));
        check("t4_w1", rd_data_2, mk(32'h5001));
        drive(0, 0, 32'h0, 1, 1);
        check("t4_w2", rd_data_1, mk(32'h5002));
        check("t4_w3", rd_data_2, mk(32'h5003));
        check("t4_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));

        // Simultaneous write 8 and pop 2 at Count=10.
        do_reset();
        drive(1, 8, 32'h6000, 0, 0);
        drive(1, 2, 32'h6008, 0, 0);
        check("t5_count_10", LOC_WIDTH'(Count), LOC_WIDTH'(10));
        drive(1, 8, 32'h6100, 1, 1);
        check("t5_count_16", LOC_WIDTH'(Count), LOC_WIDTH'(16));
        check("t5_rd1", rd_data_1, mk(32'h6000));
        check("t5_rd2", rd_data_2, mk(32'h6001));

        // Reset wins over a same-cycle read; buffer then reads as empty.
        drive(1, 2, 32'h7000, 0, 0);
        rst = 1'b1;
        drive(0, 0, 32'h0, 1, 0);
        rst = 1'b0;
        check("t6_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));
        check("t6_empty_loc", LOC_WIDTH'(empty_loc), LOC_WIDTH'(256));
        check("t6_rd1", rd_data_1, LOC_WIDTH'(0));
        check("t6_rd2", rd_data_2, LOC_WIDTH'(0));
`ifdef FRAG_BUF_ERR_EN
        check("t6_ovf", LOC_WIDTH'(ovf_err), LOC_WIDTH'(0));
        check("t6_udf", LOC_WIDTH'(udf_err), LOC_WIDTH'(0));
`endif
        drive(0, 0, 32'h0, 1, 0);
        check("t6_post_rd_count", LOC_WIDTH'(Count), LOC_WIDTH'(0));
        check("t6_post_rd1", rd_data_1, LOC_WIDTH'(0));

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frag_data_buffer.md
Name: frag_data_buffer

Overview:
Circular storage buffer between the TX arbiter and the data fragmentation stage of the PCIe TL transmit path. The arbiter pushes 1..8 payload locations (4 DW each) per cycle. The fragmentation stage pops 1 or 2 locations per cycle, and the popped data is registered. The block implements the buffer modport of buffer_frag_interface and reports Count (occupancy) and empty_loc (free space).

Parameters:
DW, 32, double-word width in bits
LOC_WIDTH, 4*DW (128), width of one storage location
DEPTH, 256, number of locations; must be a power of 2
MAX_WR_LOC, 8, max locations written per cycle
WR_DATA_WIDTH, MAX_WR_LOC*LOC_WIDTH (1024), write bus width
NO_LOC_WR_WIDTH, 4, width of no_loc_wr (encodes 0..8)
COUNT_WIDTH, 9, width of Count/empty_loc (encodes 0..DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  write request
data_in  in  WR_DATA_WIDTH  location i = data_in[i*LOC_WIDTH +: LOC_WIDTH], location 0 written first
no_loc_wr  in  NO_LOC_WR_WIDTH  number of locations to write, 1..8
empty_loc  out  COUNT_WIDTH  free locations = DEPTH - Count
rd_en  in  1  read request
rd_mode  in  1  0: pop 1 location; 1: pop 2 locations
rd_data_1  out  LOC_WIDTH  first (oldest) popped location
rd_data_2  out  LOC_WIDTH  second popped location; 0 when rd_mode=0
Count  out  COUNT_WIDTH  stored locations
ovf_err  out  1  (FRAG_BUF_ERR_EN only) sticky write-overflow flag
udf_err  out  1  (FRAG_BUF_ERR_EN only) sticky read-underflow flag

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, Count=0, empty_loc=DEPTH, rd_data_1=0, rd_data_2=0, ovf_err=0, udf_err=0.
  - rst has priority over any same-cycle wr_en/rd_en.
  - Storage contents are don't-care after reset.
- Pointers: log2(DEPTH) bits (8). Wrap modulo DEPTH naturally. Count is held as a separate 9-bit register.
- empty_loc: combinational, DEPTH - Count.
- Write acceptance:
  - wr_ok = wr_en && no_loc_wr!=0 && no_loc_wr<=MAX_WR_LOC && no_loc_wr<=empty_loc, using the current-cycle empty_loc.
  - A same-cycle pop does not free space for the write.
  - On wr_ok, location i (i < no_loc_wr) is written to mem[(wr_ptr+i) mod DEPTH], and wr_ptr += no_loc_wr.
  - Example of wrap: wr_ptr=254 with no_loc_wr=4 writes indices 254, 255, 0, 1.
- Write rejection: wr_en with an illegal or too-large no_loc_wr writes nothing and leaves pointers unchanged (a partial write never happens). ovf_err is set only for no_loc_wr > empty_loc.
- Read acceptance:
  - need = rd_mode ? 2 : 1.
  - rd_ok = rd_en && Count >= need, using the current-cycle Count. Data written in the same cycle is not readable (no write-through).
- On rd_ok, at the next posedge:
  - rd_data_1 <= mem[rd_ptr].
  - rd_data_2 <= rd_mode ? mem[(rd_ptr+1) mod DEPTH] : 0.
  - rd_ptr += need.
  - Read latency is 1 cycle: data is valid in the cycle after rd_en is sampled.
- rd_data hold rule: rd_data_1/rd_data_2 keep their previous values when there is no rd_ok, including a rejected read. A rejected read sets udf_err.
- Count update: Count <= Count + (wr_ok ? no_loc_wr : 0) - (rd_ok ? need : 0).
  - Simultaneous accepted read and write are both applied in the same cycle.
- Boundaries:
  - Full (Count=256): every write is rejected.
  - Count=1 with rd_mode=1: rejected; nothing is popped.
  - Empty (Count=0): every read is rejected.
  - Count never exceeds DEPTH and never goes negative.
- Reset mid-operation: in-flight data is discarded, and the first read after reset sees an empty buffer.

Optional Feature:
FRAG_BUF_ERR_EN:
- Defined: ovf_err and udf_err ports exist. They are sticky, set by the rejected-write and rejected-read conditions above, and cleared only by rst.
- Undefined: these ports and their logic are absent; rejected operations are silently ignored.
- Datapath behaviour is identical in both builds.

Decomposition:
- data_frag_package holds the shared constants DW, LOC_WIDTH, DEPTH, MAX_WR_LOC, WR_DATA_WIDTH, NO_LOC_WR_WIDTH and COUNT_WIDTH. buffer_frag_interface and this block share them.
- Sub-module frag_buf_mem is the natural split:
  - DEPTH x LOC_WIDTH register array with 8 write lanes (per-lane enable and index) and 2 combinational read ports (index, index+1).
  - The top level owns the pointers, Count, acceptance logic, rd_data registers and error flags.

Test Plan:
1. Reset, then write no_loc_wr=3 with locations A, B, C -> Count=3, empty_loc=253. rd_en=1, rd_mode=1 -> next cycle rd_data_1=A, rd_data_2=B, Count=1.
2. Count=1, rd_en=1, rd_mode=1 -> Count stays 1, rd_data unchanged, udf_err=1. Then rd_mode=0 -> rd_data_1=C, rd_data_2=0, Count=0.
3. Fill to Count=252, then write no_loc_wr=5 -> rejected, Count=252, ovf_err=1. Then write no_loc_wr=4 -> Count=256, empty_loc=0.
4. Wrap: drive wr_ptr=rd_ptr=254 via traffic, write 4 locations W0..W3, pop 2, then pop 2 -> first pop gives W0/W1 (indices 254, 255), second gives W2/W3 (indices 0, 1).
5. Count=10 with simultaneous write no_loc_wr=8 and read rd_mode=1 -> Count=16 next cycle, popped data equals the oldest two entries.
6. Write 2 locations then assert rst in the following cycle together with rd_en=1 -> Count=0, empty_loc=256, rd_data_1=rd_data_2=0, error flags=0.
